// File: rtl/store_align_buffer_if.sv
// Store request / data-memory drain bundle for store_align_buffer.
// slave: buffer side; master: MEM stage and data memory side.
interface store_align_buffer_if;
    // MEM-stage store request
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_err;
    // data-memory write port
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    // ordering status
    logic        empty;

    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ack,
        input  st_ready, st_err, mem_req, mem_addr,
        input  mem_wdata, mem_wstrb, empty
    );

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ack,
        output st_ready, st_err, mem_req, mem_addr,
        output mem_wdata, mem_wstrb, empty
    );
endinterface

// File: rtl/store_align_buffer.sv
// Store align buffer: lane-aligns SB/SH/SW with strobes, queues them in a
// DEPTH-entry FIFO and drains over mem_req/mem_ack. Ports: clk, rst, bus(slave).
module store_align_buffer #(
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    store_align_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          err_q;

    logic   full;
    logic   nonempty;
    logic   accept;
    logic   illegal;
    logic   push;
    logic   pop;
    entry_t new_e;
    entry_t head;

    assign full     = (count == FULL_CNT);
    assign nonempty = (count != '0);
    // Acceptance looks only at the registered count: a retire in the
    // same cycle does not free a slot until the next cycle.
    assign accept   = bus.st_valid && !full;
    assign push     = accept && !illegal;
    assign pop      = nonempty && bus.mem_ack;

    always_comb begin
        illegal = 1'b0;
        unique case (bus.st_size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = bus.st_addr[0];
            2'b10:   illegal = |bus.st_addr[1:0];
            default: illegal = 1'b1;
        endcase
    end

    // Replicate the low bytes into every lane; the strobe picks the lane.
    always_comb begin
        new_e.waddr = bus.st_addr[31:2];
        new_e.wdata = bus.st_data;
        new_e.wstrb = 4'b1111;
        unique case (bus.st_size)
            2'b00: begin
                new_e.wdata = {4{bus.st_data[7:0]}};
                new_e.wstrb = 4'b0001 << bus.st_addr[1:0];
            end
            2'b01: begin
                new_e.wdata = {2{bus.st_data[15:0]}};
                new_e.wstrb = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                new_e.wdata = bus.st_data;
                new_e.wstrb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr] <= new_e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err_q <= accept && illegal;
        end
    end

    assign head = fifo_q[rd_ptr];

    // Outputs are forced to zero while empty so a stale slot never shows.
    assign bus.st_ready  = !full;
    assign bus.st_err    = err_q;
    assign bus.mem_req   = nonempty;
    assign bus.empty     = !nonempty;
    assign bus.mem_addr  = nonempty ? {head.waddr, 2'b00} : '0;
    assign bus.mem_wdata = nonempty ? head.wdata : '0;
    assign bus.mem_wstrb = nonempty ? head.wstrb : '0;
endmodule
